ram_16x8_arbiter_rr: RTL and testbench
======================================

Name: ram_16x8_arbiter_rr

Overview:
- Two-requester round-robin arbiter and sequencer that shares one single-port 16x8 synchronous RAM (registered read, write on posedge when we=1) between requester A and requester B.
- Sits between two client blocks and the RAM instance.
- Drives the RAM's we/address/data_in and captures its data_out.
- Each accepted request runs through a fixed 4-state sequence and returns a one-cycle ack, plus read data for reads.

Parameters:
- ADDR_W, 4, RAM address width (16 words).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req_a / req_b  in  1  level request from A / B; held with its fields until ack.
- we_a / we_b  in  1  1=write, 0=read.
- addr_a / addr_b  in  ADDR_W  target address.
- wdata_a / wdata_b  in  DATA_W  write data.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- rdata_a / rdata_b  out  DATA_W  read result, valid with ack, held until next read completes.
- ram_we  out  1  to RAM we.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_data_out  in  DATA_W  from RAM data_out.
- busy  out  1  1 whenever state != IDLE.
- grant_cnt_a / grant_cnt_b  out  8  completed-transaction counters (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - ram_we=0, ram_address=0, ram_data_in=0.
  - ack_a=ack_b=0, rdata_a=rdata_b=0, busy=0.
  - last_winner=B, so A wins the first tie.
  - Reset mid-transaction aborts it: no ack is issued, and a write cut short still performs at most the single RAM edge already issued.
- FSM states IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE. All outputs are registered.
  - IDLE: on posedge with any req high, pick the winner and register ram_we/ram_address/ram_data_in from its fields. Go to ISSUE. With no req, stay in IDLE with ram_we=0.
  - ISSUE: the RAM samples its inputs on this posedge. Register ram_we=0 and go to CAPTURE.
  - CAPTURE: ram_data_out is valid. On posedge, if the transaction is a read, load rdata_<winner> from ram_data_out. Assert ack_<winner>=1, update last_winner=winner, go to ACK.
  - ACK: ack high for exactly this one cycle. On posedge, clear ack and go to IDLE. req is not sampled in ACK.
- Latency: req seen at edge E0 -> ack high during the cycle after edge E2. Throughput is one transaction per 4 cycles. The two acks are never high together.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_winner wins, which guarantees strict alternation under continuous contention.
- The loser keeps its req high and is served in the next IDLE.
- A requester holding req high after its ack starts a new transaction, using the fields present at the next IDLE edge.
- A write transaction leaves rdata unchanged.
- Requester fields are sampled only at the IDLE edge; changes after that are ignored.
- Address 4'hF and address 4'h0 get no special treatment; there is no wrap logic because the address is passed straight through.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined: grant_cnt_a/grant_cnt_b increment by 1 in the same cycle ack_a/ack_b is set. They saturate at 8'hFF and clear to 0 on reset.
- Undefined: no counter logic is compiled in, and grant_cnt_a/grant_cnt_b are tied to 8'h00.
- The port list is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_a=req_b=1 -> ram_we=0, ack_a=ack_b=0, busy=0, rdata_a=rdata_b=8'h00 throughout.
- Single writer then reader:
  - A writes addr 4'h3 data 8'hA3 -> ack_a after 3 edges, ram_we high exactly one cycle.
  - A then reads addr 4'h3 -> rdata_a=8'hA3 with ack_a.
- Contention: both req high from reset release, A reads 4'h1 (preloaded 8'hB1) and B reads 4'h2 (preloaded 8'hB2) -> ack_a first with rdata_a=8'hB1, then ack_b 4 cycles later with rdata_b=8'hB2. Then A again; acks strictly alternate over 8 transactions.
- Fill/dump all 16 addresses: B writes {4'hC,i} for i=0..15, then A reads i=0..15 -> each rdata_a={4'hC,i}, zero mismatches, rdata_b unchanged.
- Reset mid-op: assert rst_n=0 while in CAPTURE -> no ack issued, state IDLE, busy=0 on the next cycle. The re-issued request completes normally.
- With RAM_ARB_STATS_EN defined: 300 A transactions -> grant_cnt_a=8'hFF (saturated) and grant_cnt_b=8'h00. Without the macro, both counters read 8'h00.

Source files
------------

// File: rtl/ram_16x8_arbiter_rr.sv
// Round-robin arbiter/sequencer sharing one 16x8 synchronous RAM between requesters A and B.
// Optional grant counters are compiled in with `define RAM_ARB_STATS_EN.
module ram_16x8_arbiter_rr #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic [7:0]        grant_cnt_a,
    output logic [7:0]        grant_cnt_b
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_t;

    state_t              state_q, state_d;
    logic                winner_q, winner_d;        // 0 = A, 1 = B
    logic                last_winner_q, last_winner_d;
    logic                is_write_q, is_write_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_data_in_q, ram_data_in_d;
    logic                pick_b;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        pick_b = 1'b0;
        if (req_a && req_b) begin
            pick_b = ~last_winner_q;
        end else if (req_b) begin
            pick_b = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        last_winner_d = last_winner_q;
        is_write_d    = is_write_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        rdata_a_d     = rdata_a_q;
        rdata_b_d     = rdata_b_q;
        ram_we_d      = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    winner_d      = pick_b;
                    is_write_d    = pick_b ? we_b : we_a;
                    ram_we_d      = pick_b ? we_b : we_a;
                    ram_address_d = pick_b ? addr_b : addr_a;
                    ram_data_in_d = pick_b ? wdata_b : wdata_a;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!is_write_q) begin
                    if (winner_q) begin
                        rdata_b_d = ram_data_out;
                    end else begin
                        rdata_a_d = ram_data_out;
                    end
                end
                ack_a_d       = ~winner_q;
                ack_b_d       = winner_q;
                last_winner_d = winner_q;
                state_d       = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            winner_q      <= 1'b0;
            last_winner_q <= 1'b1;
            is_write_q    <= 1'b0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            is_write_q    <= is_write_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            rdata_a_q     <= rdata_a_d;
            rdata_b_q     <= rdata_b_d;
            ram_we_q      <= ram_we_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [7:0] grant_cnt_a_q, grant_cnt_a_d;
    logic [7:0] grant_cnt_b_q, grant_cnt_b_d;

    // Counts rise on the same edge that sets the matching ack; saturating.
    always_comb begin
        grant_cnt_a_d = grant_cnt_a_q;
        grant_cnt_b_d = grant_cnt_b_q;
        if (state_q == CAPTURE) begin
            if (!winner_q && grant_cnt_a_q != 8'hFF) begin
                grant_cnt_a_d = grant_cnt_a_q + 8'd1;
            end
            if (winner_q && grant_cnt_b_q != 8'hFF) begin
                grant_cnt_b_d = grant_cnt_b_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_a_q <= '0;
            grant_cnt_b_q <= '0;
        end else begin
            grant_cnt_a_q <= grant_cnt_a_d;
            grant_cnt_b_q <= grant_cnt_b_d;
        end
    end

    assign grant_cnt_a = grant_cnt_a_q;
    assign grant_cnt_b = grant_cnt_b_q;
`else
    assign grant_cnt_a = 8'h00;
    assign grant_cnt_b = 8'h00;
`endif

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;
    assign ram_we      = ram_we_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_16x8_arbiter_rr.sv
// Directed, table-driven bench for ram_16x8_arbiter_rr with a behavioural 16x8 RAM attached.
module tb_ram_16x8_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, we_a, req_b, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b;
    logic [7:0] rdata_a, rdata_b;
    logic       ram_we;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;
    logic       busy;
    logic [7:0] grant_cnt_a, grant_cnt_b;

    logic       pre_we;
    logic [3:0] pre_addr;
    logic [7:0] pre_data;
    logic [7:0] mem [16];

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_a, exp_b;

    typedef struct {
        bit         side;   // 0 = A, 1 = B
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [34];

    always #5 clk = ~clk;

    // Registered-read single-port RAM; pre_we is a bench-only back door for preloading.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    ram_16x8_arbiter_rr #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_a(ack_a), .rdata_a(rdata_a), .ack_b(ack_b), .rdata_b(rdata_b),
        .ram_we(ram_we), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .busy(busy),
        .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_txn(input bit side, input bit we, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [7:0] er, input string tag);
        int lat = 0;
        int we_cycles = 0;
        bit got = 0;
        if (!side) begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end else begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (ram_we) we_cycles++;
            if (side ? ack_b : ack_a) got = 1'b1;
            if (lat == 1) begin
                // fields may change once accepted; the DUT must ignore them
                we_a = ~we_a; addr_a = ~addr_a; wdata_a = ~wdata_a;
                we_b = ~we_b; addr_b = ~addr_b; wdata_b = ~wdata_b;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk($sformatf("%s ack", tag), 32'(got), 32'd1);
        chk($sformatf("%s latency", tag), 32'(lat), 32'd3);
        chk($sformatf("%s ram_we_cycles", tag), 32'(we_cycles), we ? 32'd1 : 32'd0);
        chk($sformatf("%s other_ack", tag), 32'(side ? ack_a : ack_b), 32'd0);
        if (!we) begin
            if (side) exp_b = er;
            else exp_a = er;
        end
        chk($sformatf("%s rdata_a", tag), 32'(rdata_a), 32'(exp_a));
        chk($sformatf("%s rdata_b", tag), 32'(rdata_b), 32'(exp_b));
        @(negedge clk);
        chk($sformatf("%s idle_busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s ack_cleared", tag), 32'(ack_a | ack_b), 32'd0);
    endtask

    initial begin
        int gap;
        bit got;
        int cnt_exp_a;

        // Table: A write/read at 3, B fills all 16 words, A dumps them.
        vecs[0] = '{side: 1'b0, we: 1'b1, addr: 4'h3, wdata: 8'hA3, exp_rdata: 8'h00};
        vecs[1] = '{side: 1'b0, we: 1'b0, addr: 4'h3, wdata: 8'h00, exp_rdata: 8'hA3};
        for (int i = 0; i < 16; i++) begin
            vecs[2 + i]  = '{side: 1'b1, we: 1'b1, addr: 4'(i), wdata: {4'hC, 4'(i)}, exp_rdata: 8'h00};
            vecs[18 + i] = '{side: 1'b0, we: 1'b0, addr: 4'(i), wdata: 8'h5A, exp_rdata: {4'hC, 4'(i)}};
        end

        rst_n = 1'b0;
        pre_we = 1'b0; pre_addr = 4'h0; pre_data = 8'h00;
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'h1; wdata_a = 8'h00;
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'h2; wdata_b = 8'h00;

        // Reset held 3 cycles with both requests up; preload 1 and 2 meanwhile.
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin pre_we = 1'b1; pre_addr = 4'h1; pre_data = 8'hB1; end
            if (c == 1) begin pre_we = 1'b1; pre_addr = 4'h2; pre_data = 8'hB2; end
            if (c == 2) pre_we = 1'b0;
            @(negedge clk);
            chk("reset ram_we", 32'(ram_we), 32'd0);
            chk("reset acks", 32'({ack_a, ack_b}), 32'd0);
            chk("reset busy", 32'(busy), 32'd0);
            chk("reset rdata", 32'({rdata_a, rdata_b}), 32'd0);
        end
        pre_we = 1'b0;
        exp_a = 8'h00;
        exp_b = 8'h00;

        // Contention: both held; acks alternate A,B,A,... at 4-cycle spacing.
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            gap = 0;
            got = 1'b0;
            while (!got && gap < 8) begin
                @(negedge clk);
                gap++;
                if (ack_a || ack_b) got = 1'b1;
            end
            chk($sformatf("cont%0d got_ack", k), 32'(got), 32'd1);
            chk($sformatf("cont%0d gap", k), 32'(gap), (k == 0) ? 32'd3 : 32'd4);
            chk($sformatf("cont%0d acks", k), 32'({ack_a, ack_b}), (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k % 2 == 0) exp_a = 8'hB1;
            else exp_b = 8'hB2;
            chk($sformatf("cont%0d rdata_a", k), 32'(rdata_a), 32'(exp_a));
            chk($sformatf("cont%0d rdata_b", k), 32'(rdata_b), 32'(exp_b));
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        chk("cont idle busy", 32'(busy), 32'd0);

        for (int v = 0; v < 34; v++) begin
            do_txn(vecs[v].side, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp_rdata, $sformatf("vec%0d", v));
        end

        // Reset while in CAPTURE: no ack, idle next cycle, rdata cleared.
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'h5; wdata_a = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst ack_a", 32'(ack_a), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rdata_a", 32'(rdata_a), 32'd0);
        chk("midrst ram_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;
        req_a = 1'b0;
        exp_a = 8'h00;
        exp_b = 8'h00;
        do_txn(1'b0, 1'b0, 4'h5, 8'h00, 8'hC5, "reissue");
        chk("midrst mem5 intact", 32'(mem[5]), 32'hC5);

`ifdef RAM_ARB_STATS_EN
        cnt_exp_a = 1;
`else
        cnt_exp_a = 0;
`endif
        chk("cnt_a after reissue", 32'(grant_cnt_a), 32'(cnt_exp_a));
        chk("cnt_b after reissue", 32'(grant_cnt_b), 32'd0);

        for (int n = 0; n < 300; n++) begin
            do_txn(1'b0, 1'b0, 4'h0, 8'h00, 8'hC0, $sformatf("stat%0d", n));
        end
`ifdef RAM_ARB_STATS_EN
        cnt_exp_a = 255;
`else
        cnt_exp_a = 0;
`endif
        chk("cnt_a saturate", 32'(grant_cnt_a), 32'(cnt_exp_a));
        chk("cnt_b zero", 32'(grant_cnt_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
